data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, data-memory size in 32-bit words (byte range 0..4*DEPTH-1).
REQ-002 Parameter LATENCY, default 2, wait cycles from request accept to response (legal 0..15).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 mem_read  input  1  read request from the memory-access stage.
REQ-006 mem_write  input  1  write request from the memory-access stage.
REQ-007 mem_addr  input  32  byte address of the access.
REQ-008 mem_data_wr  input  32  write data.
REQ-009 mem_data_rd  output  32  read data, valid while mem_ready=1 for a read.
REQ-010 mem_ready  output  1  one-cycle pulse: access complete.
REQ-011 mem_error  output  1  one-cycle pulse with mem_ready: access rejected.

Function
REQ-012 The block SHALL implement FSM states IDLE, WAIT, DONE.
REQ-013 IDLE: on (mem_read|mem_write)=1, latch addr, data, rd/wr flags, go WAIT (LATENCY>0) or DONE (LATENCY=0); otherwise stay IDLE.
REQ-014 WAIT: down-counter loaded with LATENCY-1 at accept; decrement each cycle; go DONE when count=0; request inputs ignored.
REQ-015 DONE: drive mem_ready=1 for exactly one cycle, then IDLE unconditionally.
REQ-016 Accept-to-mem_ready latency SHALL be exactly LATENCY+1 cycles.
REQ-017 A request still asserted in the IDLE cycle after DONE SHALL be accepted as a new access (back-to-back, one idle cycle between).
REQ-018 Error conditions, checked on latched values: mem_read&mem_write both 1; addr[1:0]!=0; addr[31:2]>=DEPTH.
REQ-019 On error: mem_error=1 with mem_ready in DONE, no array write, mem_data_rd=0.
REQ-020 Valid write: array[addr[31:2]] <= latched data on the DONE clock edge only; mem_data_rd=0.
REQ-021 Valid read: mem_data_rd = array[addr[31:2]] registered so it is stable throughout the DONE cycle.
REQ-022 Outside DONE, mem_ready=0, mem_error=0, mem_data_rd=0.
REQ-023 A write followed by a read of the same word SHALL return the new data (no stale forwarding window).
REQ-024 Input changes during WAIT/DONE SHALL NOT alter the access in flight.

Reset
REQ-025 rst=1 at a clock edge: state=IDLE, counter=0, latched request cleared, mem_ready=0, mem_error=0, mem_data_rd=0.
REQ-026 rst asserted in WAIT or DONE SHALL abort the access; a pending write SHALL NOT commit; no mem_ready pulse.
REQ-027 Array contents SHALL NOT be cleared by rst.
REQ-028 First request may be accepted in the first cycle after rst deasserts.

Verification
REQ-029 LATENCY=2: write 0xDEADBEEF to 0x10, then read 0x10 -> each mem_ready 3 cycles after accept; read returns 0xDEADBEEF, mem_error=0.
REQ-030 Read addr 0x12 (misaligned) -> mem_ready=1, mem_error=1, mem_data_rd=0; word at 0x10 unchanged.
REQ-031 DEPTH=256: write to 0x400 -> mem_error=1; read 0x3FC returns previously written value, no corruption.
REQ-032 mem_read=mem_write=1 at 0x20 -> mem_error=1; subsequent read of 0x20 returns prior content.
REQ-033 Write 0x12345678 to 0x30, assert rst during WAIT -> no mem_ready; later read 0x30 returns old value.
REQ-034 LATENCY=0, mem_read held high to 0x0 -> mem_ready every 2nd cycle, never two consecutive cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the memory-access stage.
// Fixed-latency single-outstanding access with address/conflict checking.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_wr,
  output logic [31:0] mem_data_rd,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [31:0] rdata_q, rdata_d;
  logic        go_done;

  logic [31:0] mem_q [DEPTH];

  function automatic logic bad_access(
    input logic        rd,
    input logic        wr,
    input logic [31:0] a
  );
    return (rd & wr) | (a[1:0] != 2'b00) |
      ({2'b00, a[31:2]} >= 32'(DEPTH));
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    rdata_d = 32'd0;
    go_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read | mem_write) begin
          addr_d = mem_addr;
          data_d = mem_data_wr;
          rd_d   = mem_read;
          wr_d   = mem_write;
          cnt_d  = LAT_M1;
          if (LATENCY == 0) go_done = 1'b1;
          else state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) go_done = 1'b1;
        else cnt_d = cnt_q - 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Response is computed on entry to DONE so it is flop-stable there
    if (go_done) begin
      state_d = DONE;
      ready_d = 1'b1;
      error_d = bad_access(rd_d, wr_d, addr_d);
      if (!error_d && rd_d) rdata_d = mem_q[addr_d[AW+1:2]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never reset; a write lands on the edge leaving DONE
  always_ff @(posedge clk) begin
    if (!rst && state_q == DONE && wr_q && !error_q)
      mem_q[addr_q[AW+1:2]] <= data_q;
  end

  assign mem_ready   = ready_q;
  assign mem_error   = error_q;
  assign mem_data_rd = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a transaction-level
// model, plus directed accesses with literal expectations.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int L     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_data_wr;
  logic [31:0] mem_data_rd;
  logic        mem_ready, mem_error;

  logic        r0, w0;
  logic [31:0] a0, d0;
  logic [31:0] q0;
  logic        rdy0, err0;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data_wr(mem_data_wr),
    .mem_data_rd(mem_data_rd),
    .mem_ready(mem_ready), .mem_error(mem_error)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .mem_read(r0), .mem_write(w0),
    .mem_addr(a0), .mem_data_wr(d0),
    .mem_data_rd(q0),
    .mem_ready(rdy0), .mem_error(err0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Transaction-level model: an access accepted at edge n responds
  // in the cycle after edge n+L, commits at n+L+1, and the next
  // access may be accepted at edge n+L+2.
  logic [31:0] mm [DEPTH];
  bit          known [DEPTH];
  int          n = 0;
  int          free_at = 0;
  int          done_edge = 0;
  bit          pend = 0;
  bit          model_on = 0;
  bit          p_err, p_wr, p_known;
  int          p_idx;
  logic [31:0] p_d, p_q;
  logic        e_rdy, e_err, e_known;
  logic [31:0] e_q;

  always @(posedge clk) begin
    n++;
    e_rdy = 0; e_err = 0; e_q = 0; e_known = 1;
    if (rst) begin
      pend = 0;
      free_at = n + 1;
      model_on = 1;
    end else begin
      if (pend && n == done_edge) begin
        e_rdy = 1; e_err = p_err; e_q = p_q; e_known = p_known;
      end
      if (pend && n == done_edge + 1) begin
        if (p_wr && !p_err) begin
          mm[p_idx] = p_d;
          known[p_idx] = 1;
        end
        pend = 0;
      end
      if (!pend && n >= free_at && (mem_read || mem_write)) begin
        p_err = (mem_read && mem_write) || (mem_addr % 4 != 0) ||
                (mem_addr >= 32'(4 * DEPTH));
        p_idx = int'(mem_addr >> 2);
        p_wr = mem_write && !mem_read;
        p_d = mem_data_wr;
        p_q = 0;
        p_known = 1;
        if (!p_err && mem_read) begin
          p_q = mm[p_idx];
          p_known = known[p_idx];
        end
        done_edge = n + L;
        free_at = n + L + 2;
        pend = 1;
        if (L == 0) begin
          e_rdy = 1; e_err = p_err; e_q = p_q; e_known = p_known;
        end
      end
    end
    #1;
    if (model_on) begin
      chk("cyc_ready", 32'(mem_ready), 32'(e_rdy));
      chk("cyc_error", 32'(mem_error), 32'(e_err));
      if (e_known) chk("cyc_rdata", mem_data_rd, e_q);
    end
  end

  task automatic junk_or_idle(input bit junk);
    if (junk) begin
      mem_read    = 1'($urandom);
      mem_write   = 1'($urandom);
      mem_addr    = $urandom;
      mem_data_wr = $urandom;
    end else begin
      mem_read = 0;
      mem_write = 0;
    end
  endtask

  task automatic acc(input bit now, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit junk, output logic [31:0] q,
                     output logic e, output int lat);
    if (!now) @(negedge clk);
    mem_read = r; mem_write = w; mem_addr = a; mem_data_wr = d;
    @(negedge clk);
    junk_or_idle(junk);
    lat = 1;
    while (mem_ready !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      junk_or_idle(junk);
    end
    chk("ready_timeout", 32'(mem_ready), 32'd1);
    q = mem_data_rd;
    e = mem_error;
  endtask

  logic [31:0] q;
  logic        e;
  int          lat;
  int          ones;
  logic        prev;
  logic [31:0] ra;
  int          kind;

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; mem_addr = 0;
    mem_data_wr = 0; r0 = 0; w0 = 0; a0 = 0; d0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_error", 32'(mem_error), 32'd0);
    chk("rst_rdata", mem_data_rd, 32'd0);
    rst = 0;

    acc(1, 0, 1, 32'h10, 32'hDEADBEEF, 0, q, e, lat);
    chk("wr10_lat", 32'(lat), 32'd3);
    chk("wr10_err", 32'(e), 32'd0);
    acc(0, 1, 0, 32'h10, 0, 0, q, e, lat);
    chk("rd10_lat", 32'(lat), 32'd3);
    chk("rd10_data", q, 32'hDEADBEEF);
    chk("rd10_err", 32'(e), 32'd0);

    acc(0, 1, 0, 32'h12, 0, 0, q, e, lat);
    chk("rd12_err", 32'(e), 32'd1);
    chk("rd12_data", q, 32'd0);
    acc(0, 1, 0, 32'h10, 0, 1, q, e, lat);
    chk("rd10_again", q, 32'hDEADBEEF);

    acc(0, 0, 1, 32'h3FC, 32'hCAFEF00D, 0, q, e, lat);
    acc(0, 0, 1, 32'h0, 32'h00000001, 0, q, e, lat);
    acc(0, 0, 1, 32'h400, 32'hBAD00BAD, 0, q, e, lat);
    chk("wr400_err", 32'(e), 32'd1);
    acc(0, 1, 0, 32'h3FC, 0, 0, q, e, lat);
    chk("rd3fc_data", q, 32'hCAFEF00D);
    acc(0, 1, 0, 32'h0, 0, 0, q, e, lat);
    chk("rd0_data", q, 32'h00000001);

    acc(0, 0, 1, 32'h20, 32'h11112222, 0, q, e, lat);
    acc(0, 1, 1, 32'h20, 32'h99999999, 0, q, e, lat);
    chk("rdwr20_err", 32'(e), 32'd1);
    chk("rdwr20_data", q, 32'd0);
    acc(0, 1, 0, 32'h20, 0, 0, q, e, lat);
    chk("rd20_data", q, 32'h11112222);

    acc(0, 0, 1, 32'h30, 32'h0BADF00D, 0, q, e, lat);
    @(negedge clk);
    mem_write = 1; mem_addr = 32'h30; mem_data_wr = 32'h12345678;
    @(negedge clk);
    mem_write = 0; rst = 1;
    ones = 0;
    @(negedge clk);
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_ready === 1'b1) ones++;
    end
    chk("rst_abort_ready", 32'(ones), 32'd0);
    acc(1, 1, 0, 32'h30, 0, 0, q, e, lat);
    chk("rd30_old", q, 32'h0BADF00D);

    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 9));
      ra = 32'($urandom_range(0, 15)) << 2;
      if (kind == 0) ra = ra | 32'($urandom_range(1, 3));
      if (kind == 1) ra = 32'(4 * DEPTH) + ($urandom & 32'hFFFC);
      if (kind == 2)
        acc(0, 1, 1, ra, $urandom, 1'($urandom), q, e, lat);
      else if ($urandom_range(0, 1) == 1)
        acc(0, 1, 0, ra, 0, 1'($urandom), q, e, lat);
      else
        acc(0, 0, 1, ra, $urandom, 1'($urandom), q, e, lat);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        mem_read = 0; mem_write = 0;
      end
    end
    @(negedge clk);
    mem_read = 0; mem_write = 0;

    w0 = 1; a0 = 0; d0 = 32'hA5A50000;
    @(negedge clk);
    w0 = 0;
    chk("l0_wr_ready", 32'(rdy0), 32'd1);
    @(negedge clk);
    r0 = 1;
    ones = 0;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy0 && prev) chk("l0_consecutive", 32'd1, 32'd0);
      if (rdy0) begin
        ones++;
        chk("l0_rd_data", q0, 32'hA5A50000);
        chk("l0_rd_err", 32'(err0), 32'd0);
      end
      prev = rdy0;
    end
    r0 = 0;
    chk("l0_pulse_count", 32'(ones), 32'd10);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
